pcie_rx_framer: RTL and testbench

- Upstream of the BAR0 mock transaction layer: parses a simplified TLP dword stream from the link into the single-cycle `{data, addr}` request strobe that layer consumes (`rx_valid`/`rx_data`/`rx_is_write`).
- Validates header type, length and alignment, drops malformed packets, counts errors.
- Enforces a minimum gap between emitted requests so the downstream read path has time to complete.

---
 rtl/pcie_rx_framer.sv | 170 +++++++++++++++++
 tb/tb_pcie_rx_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_framer.sv
// rtl/pcie_rx_framer.sv - simplified TLP dword parser producing single-cycle {data, addr} requests
// Optional per-dword parity check enabled by defining PCIE_RX_PARITY_EN.
module pcie_rx_framer #(
  parameter int MIN_GAP = 2,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_par,
  output logic             in_ready,
  output logic             rx_valid,
  output logic [63:0]      rx_data,
  output logic             rx_is_write,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DROP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_live;
  logic               r_is_wr;
  logic [31:0]        r_addr;
  logic [3:0]         r_gap;
  logic               r_rx_valid;
  logic [63:0]        r_rx_data;
  logic               r_rx_is_write;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_err_pulse;

  logic               w_xfer;
  logic               w_hdr_wr;
  logic               w_hdr_ok;
  logic               w_take_hdr;
  logic               w_err;
  logic               w_emit;
  logic               w_emit_wr;
  logic [63:0]        w_emit_data;
  logic               w_cap_wr;
  logic               w_par_err;

`ifdef PCIE_RX_PARITY_EN
  assign w_par_err = ^{in_data, in_par};
`else
  logic w_unused_par;
  assign w_unused_par = in_par;
  assign w_par_err    = 1'b0;
`endif

  // Stall only when the next dword could complete a packet inside the gap window.
  assign in_ready = r_live & ~((r_gap != 4'd0) &
                    (((r_state == S_ADDR) & ~r_is_wr) | (r_state == S_DATA)));
  assign w_xfer   = in_valid & in_ready;
  assign w_hdr_wr = (in_data[31:24] == 8'h40);
  assign w_hdr_ok = (w_hdr_wr | (in_data[31:24] == 8'h00)) & (in_data[9:0] == 10'd1);

  always_comb begin
    w_next      = r_state;
    w_err       = 1'b0;
    w_emit      = 1'b0;
    w_emit_wr   = 1'b0;
    w_emit_data = {32'h0, in_data};
    w_cap_wr    = r_is_wr;
    w_take_hdr  = 1'b0;
    if (w_xfer) begin
      case (r_state)
        S_IDLE: w_take_hdr = in_sop;
        S_ADDR: begin
          if (in_sop) begin
            w_err      = 1'b1;
            w_take_hdr = 1'b1;
          end else if (in_data[1:0] != 2'b00) begin
            w_err  = 1'b1;
            w_next = in_eop ? S_IDLE : S_DROP;
          end else if (!r_is_wr) begin
            if (in_eop) begin
              w_emit = 1'b1;
              w_next = S_IDLE;
            end else begin
              w_err  = 1'b1;
              w_next = S_DROP;
            end
          end else begin
            w_err  = in_eop;
            w_next = in_eop ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (in_sop) begin
            w_err      = 1'b1;
            w_take_hdr = 1'b1;
          end else if (in_eop) begin
            w_emit      = 1'b1;
            w_emit_wr   = 1'b1;
            w_emit_data = {in_data, r_addr};
            w_next      = S_IDLE;
          end else begin
            w_err  = 1'b1;
            w_next = S_DROP;
          end
        end
        default: if (in_eop) w_next = S_IDLE;
      endcase

      if (w_take_hdr) begin
        if (in_eop) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else if (w_hdr_ok) begin
          w_next   = S_ADDR;
          w_cap_wr = w_hdr_wr;
        end else begin
          w_err  = 1'b1;
          w_next = S_DROP;
        end
      end

      // A parity hit aborts the packet; ignored dwords (drop/idle filler) are not checked.
      if (w_par_err && (r_state != S_DROP) && !((r_state == S_IDLE) && !in_sop)) begin
        w_err  = 1'b1;
        w_emit = 1'b0;
        w_next = in_eop ? S_IDLE : S_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_live        <= 1'b0;
      r_is_wr       <= 1'b0;
      r_addr        <= 32'h0;
      r_gap         <= 4'd0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= 64'h0;
      r_rx_is_write <= 1'b0;
      r_err_cnt     <= '0;
      r_err_pulse   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_live      <= 1'b1;
      r_is_wr     <= w_cap_wr;
      r_rx_valid  <= w_emit;
      r_err_pulse <= w_err;
      if (w_xfer && (r_state == S_ADDR)) r_addr <= in_data;
      if (w_emit) begin
        r_rx_data     <= w_emit_data;
        r_rx_is_write <= w_emit_wr;
        r_gap         <= GAP_LOAD;
      end else if (r_gap != 4'd0) begin
        r_gap <= r_gap - 4'd1;
      end
      if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_is_write = r_rx_is_write;
  assign err_cnt     = r_err_cnt;
  assign err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_pcie_rx_framer.sv
// tb/tb_pcie_rx_framer.sv - directed self-checking bench for pcie_rx_framer (MIN_GAP=4, ERR_W=4)
module tb_pcie_rx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        in_par;
  logic        in_ready;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        rx_is_write;
  logic [3:0]  err_cnt;
  logic        err_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p_cnt = 0;
  int p_last = 0;
  int p_prev = 0;
  int stalls = 0;
  int exp_err = 0;
  int p_base = 0;

  pcie_rx_framer #(.MIN_GAP(4), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_par(in_par), .in_ready(in_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_write(rx_is_write),
    .err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_valid) begin
      p_cnt++;
      p_prev = p_last;
      p_last = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xsend(input logic [31:0] d, input logic s, input logic e, input logic flip);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_par   = (^d) ^ flip;
    stalls   = 0;
    while (!in_ready && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 50) check("ready_timeout", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    xsend(d, s, e, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bump_err();
    if (exp_err < 15) exp_err++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_par = 1'b0;
    #2;
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    check("rst_rx_valid", {63'h0, rx_valid}, 64'h0);
    check("rst_rx_data", rx_data, 64'h0);
    check("rst_err_cnt", {60'h0, err_cnt}, 64'h0);
    check("rst_err_pulse", {63'h0, err_pulse}, 64'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {63'h0, in_ready}, 64'h1);

    // MWr
    send(32'h40000001, 1, 0); send(32'h00001000, 0, 0); send(32'hDEADBEEF, 0, 1);
    check("mwr_valid", {63'h0, rx_valid}, 64'h1);
    check("mwr_is_write", {63'h0, rx_is_write}, 64'h1);
    check("mwr_data", rx_data, 64'hDEADBEEF_00001000);
    check("mwr_err_cnt", {60'h0, err_cnt}, 64'h0);
    idle(1);
    check("mwr_one_cycle", {63'h0, rx_valid}, 64'h0);
    check("mwr_data_hold", rx_data, 64'hDEADBEEF_00001000);
    idle(5);

    // Back-to-back MRd with gap enforcement
    send(32'h00000001, 1, 0); send(32'h00000040, 0, 1);
    check("mrd1_valid", {63'h0, rx_valid}, 64'h1);
    check("mrd1_is_write", {63'h0, rx_is_write}, 64'h0);
    check("mrd1_data", rx_data, 64'h00000000_00000040);
    send(32'h00000001, 1, 0);
    check("mrd2_hdr_stall", stalls, 0);
    send(32'h00000020, 0, 1);
    check("mrd2_addr_stall", stalls, 2);
    check("mrd2_valid", {63'h0, rx_valid}, 64'h1);
    check("mrd2_data", rx_data, 64'h00000000_00000020);
    idle(1);
    check("mrd_pulse_gap", p_last - p_prev, 4);
    check("pulses_so_far", p_cnt, 3);
    idle(5);

    // Bad length header dropped through eop, then a good MWr
    send(32'h40000002, 1, 0); bump_err();
    check("badlen_err_pulse", {63'h0, err_pulse}, 64'h1);
    check("badlen_err_cnt", {60'h0, err_cnt}, 64'(exp_err));
    send(32'h00001111, 0, 0); send(32'h00002222, 0, 0); send(32'h00003333, 0, 1);
    check("badlen_eop_no_err", {63'h0, err_pulse}, 64'h0);
    check("badlen_no_emit", {63'h0, rx_valid}, 64'h0);
    idle(1);
    send(32'h40000001, 1, 0); send(32'h00002000, 0, 0); send(32'h12345678, 0, 1);
    check("mwr2_valid", {63'h0, rx_valid}, 64'h1);
    check("mwr2_data", rx_data, 64'h12345678_00002000);
    idle(1);
    check("pulses_after_badlen", p_cnt, 4);
    idle(4);

    // Misaligned address, then sop in DATA reparsed as MRd
    send(32'h40000001, 1, 0); send(32'h00001002, 0, 0); bump_err();
    check("misalign_err_pulse", {63'h0, err_pulse}, 64'h1);
    send(32'h0000AAAA, 0, 1);
    check("misalign_no_emit", {63'h0, rx_valid}, 64'h0);
    check("misalign_single_err", {63'h0, err_pulse}, 64'h0);
    idle(1);
    send(32'h40000001, 1, 0); send(32'h00003000, 0, 0);
    send(32'h00000001, 1, 0); bump_err();
    check("sop_mid_err_pulse", {63'h0, err_pulse}, 64'h1);
    send(32'h00000030, 0, 1);
    check("reparse_valid", {63'h0, rx_valid}, 64'h1);
    check("reparse_is_write", {63'h0, rx_is_write}, 64'h0);
    check("reparse_data", rx_data, 64'h00000000_00000030);
    check("reparse_err_cnt", {60'h0, err_cnt}, 64'(exp_err));
    idle(5);

    // Header with eop, and a stray non-sop dword in IDLE
    send(32'h40000001, 1, 1); bump_err();
    check("hdr_eop_err", {63'h0, err_pulse}, 64'h1);
    send(32'h12345678, 0, 0);
    check("stray_no_err", {63'h0, err_pulse}, 64'h0);
    check("stray_err_cnt", {60'h0, err_cnt}, 64'(exp_err));
    idle(5);

    // Parity flipped on the MRd address dword
    p_base = p_cnt;
    send(32'h00000001, 1, 0); xsend(32'h00000050, 0, 1, 1'b1);
`ifdef PCIE_RX_PARITY_EN
    bump_err();
    check("par_no_emit", {63'h0, rx_valid}, 64'h0);
    check("par_err_pulse", {63'h0, err_pulse}, 64'h1);
`else
    check("nopar_emit", {63'h0, rx_valid}, 64'h1);
    check("nopar_data", rx_data, 64'h00000000_00000050);
`endif
    check("par_err_cnt", {60'h0, err_cnt}, 64'(exp_err));
    idle(5);

    // Saturate the 4-bit error counter
    for (int i = 0; i < 16; i++) begin
      send(32'hFF000001, 1, 1); bump_err();
      check("sat_err_pulse", {63'h0, err_pulse}, 64'h1);
    end
    check("sat_err_cnt", {60'h0, err_cnt}, 64'hF);
    idle(1);
    check("sat_pulse_clear", {63'h0, err_pulse}, 64'h0);
    check("sat_hold", {60'h0, err_cnt}, 64'hF);
    idle(5);

    // Reset in the middle of an MWr
    p_base = p_cnt;
    send(32'h40000001, 1, 0); send(32'h00004000, 0, 0);
    reset = 1'b1; #1;
    check("midrst_err_cnt", {60'h0, err_cnt}, 64'h0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h0);
    check("midrst_rx_valid", {63'h0, rx_valid}, 64'h0);
    @(negedge clk); reset = 1'b0;
    idle(2);
    send(32'h00009999, 0, 1);
    check("midrst_no_emit", {63'h0, rx_valid}, 64'h0);
    check("midrst_no_err", {63'h0, err_pulse}, 64'h0);
    idle(2);
    check("midrst_pulses", p_cnt, p_base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
